// File: rtl/dmem_dump_reader.sv
// Walks a contiguous range of data memory through a 1-cycle-latency read port and streams each word over valid/ready.
// Optional running checksum of the dumped words is enabled by defining DUMP_CHECKSUM_EN.
module dmem_dump_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    // state | meaning
    // IDLE  | waiting for start; only state where busy is low
    // RD    | memory read strobe for word idx
    // CAP   | read data returns, captured into out_data/out_addr
    // OUT   | out_valid held until the consumer accepts
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic [CNT_WIDTH-1:0]  idx;
    logic [CNT_WIDTH-1:0]  idx_inc;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  accept_start;
    logic                  handshake;

    // Truncation of {idx,00} gives the modulo-2^ADDR_WIDTH wrap for free.
    assign idx_inc      = idx + CNT_WIDTH'(1);
    assign rd_addr      = base_r + ADDR_WIDTH'({idx, 2'b00});
    assign accept_start = (state == ST_IDLE) && start;
    assign handshake    = (state == ST_OUT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (word_count == '0) ? ST_DONE : ST_RD;
            end
            ST_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = rd_addr;
                state_nxt = ST_CAP;
            end
            ST_CAP: state_nxt = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = (idx_inc == count_r) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r   <= '0;
            count_r  <= '0;
            idx      <= '0;
            out_data <= '0;
            out_addr <= '0;
        end else begin
            if (accept_start) begin
                base_r  <= base_addr & ~ADDR_WIDTH'(3);
                count_r <= word_count;
                idx     <= '0;
            end
            if (state == ST_CAP) begin
                out_data <= mem_rd_data;
                out_addr <= rd_addr;
            end
            if (handshake) idx <= idx_inc;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               checksum <= '0;
        else if (accept_start) checksum <= '0;
        else if (handshake)    checksum <= checksum + out_data;
    end
`endif

endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Read-side counterpart to the data-memory write path in the MEM stage: after a program run, it walks a contiguous range of data memory through a synchronous read port. It streams each word out over a valid/ready interface to the testbench scoreboard or a debug host. It sits beside `MEMStage` on the data-memory read port and is only active while the pipeline is quiesced.

## Interface
- `ADDR_WIDTH`, 10: byte-address width of data memory; all address arithmetic is modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32: memory word width.
- `CNT_WIDTH`, 16: width of the word-count request.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first byte address; bits [1:0] ignored (forced 00).
- `word_count`  in  CNT_WIDTH  number of words to dump; 0 is legal.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_WIDTH  word-aligned byte address of the read.
- `mem_rd_data`  in  DATA_WIDTH  read data, valid the cycle after `mem_rd_en` (1-cycle latency).
- `out_valid`  out  1  `out_data`/`out_addr` hold a word.
- `out_ready`  in  1  consumer accepts a word.
- `out_data`  out  DATA_WIDTH  dumped word.
- `out_addr`  out  ADDR_WIDTH  address that `out_data` came from.
- `busy`  out  1  dump in progress, from RD through DONE.
- `done`  out  1  one-cycle pulse at the end of a dump.
- `checksum`  out  DATA_WIDTH  present only with `DUMP_CHECKSUM_EN`.

## Operation
- FSM states: IDLE, RD, CAP, OUT, DONE.
- **IDLE**
  - `start`=1 with `word_count`≠0: latch `base_addr` (aligned) and `word_count`, set `idx`=0, go to RD.
  - `start`=1 with `word_count`=0: go to DONE (no beats).
  - `start` is ignored in every other state.
- **RD**
  - `mem_rd_en`=1, `mem_addr` = (base + 4·idx) mod 2^ADDR_WIDTH.
  - Always goes to CAP.
- **CAP**
  - Register `mem_rd_data` into `out_data` and the RD address into `out_addr`.
  - Go to OUT.
- **OUT**
  - `out_valid`=1; `out_data` and `out_addr` stay stable until handshake.
  - On `out_valid && out_ready`: increment `idx`. If `idx`+1 == count, go to DONE; else go to RD.
- **DONE**
  - `done`=1, `busy`=1 for exactly one cycle, then go to IDLE.
- Address wrap: crossing 2^ADDR_WIDTH−4 wraps to 0 silently.
- `word_count` up to 2^CNT_WIDTH−1; the counter never overflows.
- Reset values: all outputs 0, state IDLE, `checksum` 0.
- `rst` asserted mid-dump: immediate return to IDLE. No `done` pulse; any pending `out_valid` drops asynchronously.
- `mem_rd_en` is never asserted outside RD.

## Timing
- `start` sampled at edge E0 → `mem_rd_en` high in cycle E0..E1.
- First `out_valid` high after E2.
- Handshake at edge Ek → next `mem_rd_en` in cycle Ek..Ek+1.
- Next `out_valid` after Ek+2. Minimum 3 cycles per word.
- Last handshake at edge En → `done` high for cycle En..En+1; `busy` low after En+1.
- `word_count`=0: `done` high for the cycle after E0.
- `busy` is low only in IDLE.
- `out_ready` may be high before `out_valid`; there is no combinational path from `out_ready` to any output.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - Cleared to 0 when `start` is accepted.
  - On each handshake, `checksum` ← `checksum` + `out_data` (mod 2^DATA_WIDTH).
  - Final value is stable while `done`=1 and held until the next accepted `start`.
- Not defined: no `checksum` port and no accumulator logic; all other behaviour is identical.

## Test plan
- Memory word i = 0x1000_0000+i; `base_addr`=0x010, `word_count`=4, `out_ready`=1 → beats (0x010,0x1000_0004), (0x014,…05), (0x018,…06), (0x01C,…07). Beats are 3 cycles apart; `done` pulses the cycle after the 4th beat.
- `word_count`=0 → no `mem_rd_en`, no `out_valid`; `done` high one cycle after start.
- `base_addr`=0x3F8, `word_count`=4 → `mem_addr` sequence 0x3F8, 0x3FC, 0x000, 0x004.
- Hold `out_ready`=0 for 5 cycles on beat 2 → `out_data`/`out_addr` stable and no new `mem_rd_en` until accept; all data is correct afterwards.
- Assert `rst` in OUT of beat 2 of 8 → `out_valid`, `busy`, `done` go 0 immediately, with no `done` pulse. A new `start` then restarts from the new base. A `start` pulsed while busy is ignored.
- With `DUMP_CHECKSUM_EN`: words 0xFFFF_FFFF, 0x0000_0002 → `checksum`=0x0000_0001 at `done`; it resets to 0 on the next start.
